// File: rtl/chopper_pkg.sv
// Shared widths and the per-channel load-value bundle for the chopper timer bank.
package chopper_pkg;

  localparam int OFF_W   = 10;
  localparam int BLANK_W = 8;
  localparam int MINON_W = 8;
  localparam int PRE_W   = 8;
  localparam int PHASE_W = 8;

  typedef struct packed {
    logic [OFF_W-1:0]   offtime;
    logic [BLANK_W-1:0] blanktime;
    logic [MINON_W-1:0] minon;
  } chan_cfg_t;

endpackage

// File: rtl/chopper_timer_bank_channel.sv
// One phase of the chopper: off/blank/minimum-on countdowns with step-change blanking.
module chopper_channel
  import chopper_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  chan_cfg_t          cfg,
  input  logic               offtimer_en,
  input  logic [PHASE_W-1:0] phase_ct,
  output logic [OFF_W-1:0]   off_timer,
  output logic [BLANK_W-1:0] blank_timer,
  output logic [MINON_W-1:0] minon_timer
);

  logic [OFF_W-1:0]   off_q, off_d;
  logic [BLANK_W-1:0] blank_q, blank_d;
  logic [MINON_W-1:0] minon_q, minon_d;
  logic [PHASE_W-1:0] phase_cur_q, phase_prev_q;
  logic               expire, step;

  always_comb begin
    off_d   = off_q;
    blank_d = blank_q;
    minon_d = minon_q;
    expire  = tick && (off_q == OFF_W'(1));
    step    = (phase_cur_q != phase_prev_q);

    if (offtimer_en && (off_q == '0) && (cfg.offtime != '0)) begin
      off_d = cfg.offtime;
    end else if (tick && (off_q != '0)) begin
      off_d = off_q - OFF_W'(1);
    end

    // Off expiry reloads both windows and outranks a coincident step or decrement.
    if (expire) begin
      blank_d = cfg.blanktime;
      minon_d = cfg.minon;
    end else begin
      if (step) begin
        blank_d = cfg.blanktime;
      end else if (tick && (blank_q != '0)) begin
        blank_d = blank_q - BLANK_W'(1);
      end
      if (tick && (minon_q != '0)) begin
        minon_d = minon_q - MINON_W'(1);
      end
    end
  end

  // Reset seeds both phase history registers with the live input so release never looks like a step.
  always_ff @(posedge clk) begin
    if (reset) begin
      off_q        <= '0;
      blank_q      <= '0;
      minon_q      <= '0;
      phase_cur_q  <= phase_ct;
      phase_prev_q <= phase_ct;
    end else begin
      off_q        <= off_d;
      blank_q      <= blank_d;
      minon_q      <= minon_d;
      phase_cur_q  <= phase_ct;
      phase_prev_q <= phase_cur_q;
    end
  end

  assign off_timer   = off_q;
  assign blank_timer = blank_q;
  assign minon_timer = minon_q;

endmodule

// File: rtl/chopper_timer_bank.sv
// Three-phase chopper timer bank: shared tick prescaler feeding three independent channels.
module chopper_timer_bank
  import chopper_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [PRE_W-1:0]   config_prescale,
  input  logic [OFF_W-1:0]   config_offtime,
  input  logic [BLANK_W-1:0] config_blanktime,
  input  logic [MINON_W-1:0] config_minon,
  input  logic               offtimer_en0,
  input  logic               offtimer_en1,
  input  logic               offtimer_en2,
  input  logic [PHASE_W-1:0] phase_ct,
  input  logic [PHASE_W-1:0] phase_ct_B,
  input  logic [PHASE_W-1:0] phase_ct_C,
  output logic [OFF_W-1:0]   off_timer0,
  output logic [OFF_W-1:0]   off_timer1,
  output logic [OFF_W-1:0]   off_timer2,
  output logic [BLANK_W-1:0] blank_timer0,
  output logic [BLANK_W-1:0] blank_timer1,
  output logic [BLANK_W-1:0] blank_timer2,
  output logic [MINON_W-1:0] minimum_on_timer0,
  output logic [MINON_W-1:0] minimum_on_timer1,
  output logic [MINON_W-1:0] minimum_on_timer2,
  output logic               tick
);

  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic             tick_q, tick_d;
  chan_cfg_t        cfg;

  // >= lets the counter recover at once when the prescale is lowered under it.
  always_comb begin
    tick_d    = (pre_cnt_q >= config_prescale);
    pre_cnt_d = tick_d ? '0 : pre_cnt_q + PRE_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt_q <= '0;
      tick_q    <= 1'b0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      tick_q    <= tick_d;
    end
  end

  assign tick          = tick_q;
  assign cfg.offtime   = config_offtime;
  assign cfg.blanktime = config_blanktime;
  assign cfg.minon     = config_minon;

  chopper_channel u_ch0 (
    .clk(clk), .reset(reset), .tick(tick_q), .cfg(cfg),
    .offtimer_en(offtimer_en0), .phase_ct(phase_ct),
    .off_timer(off_timer0), .blank_timer(blank_timer0), .minon_timer(minimum_on_timer0)
  );

  chopper_channel u_ch1 (
    .clk(clk), .reset(reset), .tick(tick_q), .cfg(cfg),
    .offtimer_en(offtimer_en1), .phase_ct(phase_ct_B),
    .off_timer(off_timer1), .blank_timer(blank_timer1), .minon_timer(minimum_on_timer1)
  );

  chopper_channel u_ch2 (
    .clk(clk), .reset(reset), .tick(tick_q), .cfg(cfg),
    .offtimer_en(offtimer_en2), .phase_ct(phase_ct_C),
    .off_timer(off_timer2), .blank_timer(blank_timer2), .minon_timer(minimum_on_timer2)
  );

endmodule

// File: tb/tb_chopper_timer_bank.sv
// Self-checking bench for chopper_timer_bank: vector table, directed corners and a random run against a cycle model.
module tb_chopper_timer_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] cfg_pre;
  logic [9:0] cfg_off;
  logic [7:0] cfg_blank;
  logic [7:0] cfg_minon;
  logic       en [3];
  logic [7:0] ph [3];
  logic [9:0] d_off [3];
  logic [7:0] d_blank [3];
  logic [7:0] d_minon [3];
  logic       d_tick;

  int errors = 0;
  int checks = 0;

  // Model state: remaining ticks per timer, prescaler position, and the sampled phase history.
  int m_pre, m_tick;
  int m_off [3];
  int m_blank [3];
  int m_minon [3];
  int m_seen [3];
  int m_older [3];

  always #5 clk = ~clk;

  chopper_timer_bank dut (
    .clk(clk), .reset(reset),
    .config_prescale(cfg_pre), .config_offtime(cfg_off),
    .config_blanktime(cfg_blank), .config_minon(cfg_minon),
    .offtimer_en0(en[0]), .offtimer_en1(en[1]), .offtimer_en2(en[2]),
    .phase_ct(ph[0]), .phase_ct_B(ph[1]), .phase_ct_C(ph[2]),
    .off_timer0(d_off[0]), .off_timer1(d_off[1]), .off_timer2(d_off[2]),
    .blank_timer0(d_blank[0]), .blank_timer1(d_blank[1]), .blank_timer2(d_blank[2]),
    .minimum_on_timer0(d_minon[0]), .minimum_on_timer1(d_minon[1]), .minimum_on_timer2(d_minon[2]),
    .tick(d_tick)
  );

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic model_edge();
    if (reset) begin
      m_pre  = 0;
      m_tick = 0;
      for (int c = 0; c < 3; c++) begin
        m_off[c] = 0; m_blank[c] = 0; m_minon[c] = 0;
        m_seen[c] = ph[c]; m_older[c] = ph[c];
      end
    end else begin
      for (int c = 0; c < 3; c++) begin
        bit expired = (m_tick != 0) && (m_off[c] == 1);
        bit stepped = (m_seen[c] != m_older[c]);
        if (en[c] && m_off[c] == 0 && cfg_off != 0) m_off[c] = cfg_off;
        else if (m_tick != 0 && m_off[c] > 0)        m_off[c] = m_off[c] - 1;
        if (expired) begin
          m_blank[c] = cfg_blank;
          m_minon[c] = cfg_minon;
        end else begin
          if (stepped)                           m_blank[c] = cfg_blank;
          else if (m_tick != 0 && m_blank[c] > 0) m_blank[c] = m_blank[c] - 1;
          if (m_tick != 0 && m_minon[c] > 0)      m_minon[c] = m_minon[c] - 1;
        end
        m_older[c] = m_seen[c];
        m_seen[c]  = ph[c];
      end
      if (m_pre >= int'(cfg_pre)) begin m_pre = 0; m_tick = 1; end
      else begin m_pre = m_pre + 1; m_tick = 0; end
    end
  endtask

  // One clock: advance the model on the edge, then compare every output 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("tick", int'(d_tick), m_tick);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("off%0d", c),   int'(d_off[c]),   m_off[c]);
      chk($sformatf("blank%0d", c), int'(d_blank[c]), m_blank[c]);
      chk($sformatf("minon%0d", c), int'(d_minon[c]), m_minon[c]);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
    cyc();
  endtask

  typedef struct {
    logic en0;
    int   off0;
    int   blank0;
    int   minon0;
  } vec_t;
  vec_t tbl [10];

  initial begin
    int n, last_tick;
    reset = 1'b1; cfg_pre = 8'd0; cfg_off = 10'd5; cfg_blank = 8'd3; cfg_minon = 8'd4;
    for (int c = 0; c < 3; c++) begin en[c] = 1'b0; ph[c] = 8'd10 * 8'(c + 1); end

    // Reset state
    cyc(); cyc();
    chk("rst_tick", int'(d_tick), 0);
    chk("rst_off0", int'(d_off[0]), 0);
    chk("rst_blank1", int'(d_blank[1]), 0);
    chk("rst_minon2", int'(d_minon[2]), 0);
    reset = 1'b0;
    cyc();

    // Off timing table: prescale 0, offtime 5, blank 3, minon 4
    tbl[0] = '{1'b1, 5, 0, 0};
    tbl[1] = '{1'b0, 4, 0, 0};
    tbl[2] = '{1'b0, 3, 0, 0};
    tbl[3] = '{1'b0, 2, 0, 0};
    tbl[4] = '{1'b0, 1, 0, 0};
    tbl[5] = '{1'b0, 0, 3, 4};
    tbl[6] = '{1'b0, 0, 2, 3};
    tbl[7] = '{1'b0, 0, 1, 2};
    tbl[8] = '{1'b0, 0, 0, 1};
    tbl[9] = '{1'b0, 0, 0, 0};
    for (int i = 0; i < 10; i++) begin
      en[0] = tbl[i].en0;
      cyc();
      chk($sformatf("tbl%0d_off0", i),   int'(d_off[0]),   tbl[i].off0);
      chk($sformatf("tbl%0d_blank0", i), int'(d_blank[0]), tbl[i].blank0);
      chk($sformatf("tbl%0d_minon0", i), int'(d_minon[0]), tbl[i].minon0);
    end

    // Prescaler: tick every 4 clk, load latency 1 clk, countdown of 2 ticks
    cfg_pre = 8'd3; cfg_off = 10'd2;
    last_tick = -1;
    for (int i = 0; i < 16; i++) begin
      cyc();
      if (d_tick) begin
        if (last_tick > 0) chk("tick_spacing", i - last_tick, 4);
        last_tick = i;
      end
    end
    en[0] = 1'b1;
    cyc();
    en[0] = 1'b0;
    chk("pre_load_off0", int'(d_off[0]), 2);
    n = 0;
    while (d_off[0] != 10'd0 && n < 20) begin
      cyc();
      n++;
    end
    chk("pre_off_duration_in_range", int'(n >= 5 && n <= 9), 1);

    // Retrigger ignored while counting; zero offtime ignored
    cfg_pre = 8'd0; cfg_off = 10'd9;
    do_reset();
    en[1] = 1'b1;
    cyc(); cyc(); cyc();
    chk("retrig_off1_at7", int'(d_off[1]), 7);
    cyc(); chk("retrig_off1_6", int'(d_off[1]), 6);
    cyc(); chk("retrig_off1_5", int'(d_off[1]), 5);
    en[1] = 1'b0;
    do_reset();
    cfg_off = 10'd0;
    en[1] = 1'b1;
    cyc(); cyc();
    chk("zero_cfg_off1", int'(d_off[1]), 0);
    en[1] = 1'b0;

    // Step blank while idle: visible two edges after the change
    cfg_blank = 8'd6; cfg_minon = 8'd2; ph[1] = 8'd10;
    do_reset();
    ph[1] = 8'd11;
    cyc(); chk("step_idle_blank1_e0", int'(d_blank[1]), 0);
    cyc(); chk("step_idle_blank1_e1", int'(d_blank[1]), 6);

    // Step during OFF: blank reloads, off keeps counting
    cfg_off = 10'd20;
    do_reset();
    en[1] = 1'b1; cyc(); en[1] = 1'b0;
    cyc();
    ph[1] = ph[1] + 8'd1;
    cyc(); cyc();
    chk("step_off_blank1", int'(d_blank[1]), 6);
    chk("step_off_off1", int'(d_off[1]), 17);

    // Step coinciding with expiry: single load
    cfg_off = 10'd3;
    do_reset();
    en[1] = 1'b1; cyc(); en[1] = 1'b0;
    cyc();
    ph[1] = ph[1] + 8'd1;
    cyc(); cyc();
    chk("step_exp_off1", int'(d_off[1]), 0);
    chk("step_exp_blank1", int'(d_blank[1]), 6);
    chk("step_exp_minon1", int'(d_minon[1]), 2);
    cyc();
    chk("step_exp_blank1_next", int'(d_blank[1]), 5);
    chk("step_exp_minon1_next", int'(d_minon[1]), 1);

    // Channel independence
    cfg_off = 10'd7; cfg_blank = 8'd4;
    do_reset();
    en[0] = 1'b1; en[2] = 1'b1; ph[0] = ph[0] + 8'd1;
    cyc();
    en[0] = 1'b0; en[2] = 1'b0;
    cyc();
    chk("ind_off0", int'(d_off[0]), 6);
    chk("ind_off2", int'(d_off[2]), 6);
    chk("ind_blank0", int'(d_blank[0]), 4);
    chk("ind_blank2", int'(d_blank[2]), 0);
    chk("ind_off1", int'(d_off[1]), 0);
    chk("ind_blank1", int'(d_blank[1]), 0);
    ph[2] = ph[2] + 8'd3;
    cyc(); cyc();
    chk("ind_blank2_late", int'(d_blank[2]), 4);
    chk("ind_blank0_late", int'(d_blank[0]), 2);

    // Reset mid-operation with off=400, blank=5
    cfg_off = 10'd400; cfg_blank = 8'd5;
    do_reset();
    en[0] = 1'b1; cyc(); en[0] = 1'b0;
    ph[0] = ph[0] + 8'd1;
    cyc(); cyc();
    chk("mid_pre_off0", int'(d_off[0]), 398);
    chk("mid_pre_blank0", int'(d_blank[0]), 5);
    reset = 1'b1; en[0] = 1'b1;
    cyc();
    chk("mid_rst_off0", int'(d_off[0]), 0);
    chk("mid_rst_blank0", int'(d_blank[0]), 0);
    chk("mid_rst_tick", int'(d_tick), 0);
    reset = 1'b0; en[0] = 1'b0;
    cyc(); cyc(); cyc();
    chk("mid_post_blank0", int'(d_blank[0]), 0);

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        cfg_pre   = 8'($urandom_range(0, 3));
        cfg_off   = 10'($urandom_range(0, 12));
        cfg_blank = 8'($urandom_range(0, 7));
        cfg_minon = 8'($urandom_range(0, 7));
      end
      for (int c = 0; c < 3; c++) begin
        en[c] = ($urandom_range(0, 5) == 0);
        if ($urandom_range(0, 15) == 0) ph[c] = 8'($urandom);
      end
      reset = ($urandom_range(0, 499) == 0);
      cyc();
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
